// File: rtl/dmem_responder.sv
// Memory end of the core's memory-stage bus: one load/store in flight, fixed
// LATENCY-cycle wait, then a single-cycle response carrying read data or an error.
module dmem_responder #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 64,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              busy
);
  localparam int IW    = ADDR_W - 2;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(LATENCY + 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic              wr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] mem [0:DEPTH-1];

  logic [IW-1:0] idx;
  logic          err;
  logic          accept;
  logic          commit;

  // Full word index is range-checked so out-of-range addresses never alias low words.
  assign idx    = addr_q[ADDR_W-1:2];
  assign err    = (addr_q[1:0] != 2'b00) || (idx >= IW'(DEPTH));
  assign accept = req_valid && req_ready;
  assign commit = (state == WAIT) && (cnt == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      wr_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      busy      <= 1'b0;
      req_ready <= 1'b1;
    end else begin
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      case (state)
        IDLE, RESP: begin
          if (accept) begin
            wr_q      <= req_write;
            addr_q    <= req_addr;
            wdata_q   <= req_wdata;
            cnt       <= CNT_W'(LATENCY - 1);
            state     <= WAIT;
            busy      <= 1'b1;
            req_ready <= 1'b0;
          end else begin
            state     <= IDLE;
            busy      <= 1'b0;
            req_ready <= 1'b1;
          end
        end
        WAIT: begin
          if (commit) begin
            state     <= RESP;
            busy      <= 1'b0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b1;
            rsp_err   <= err;
            rsp_rdata <= (!wr_q && !err) ? mem[idx[AW-1:0]] : '0;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: begin
          state     <= IDLE;
          busy      <= 1'b0;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

  // Storage has no reset; reset forces state to IDLE at once, so an uncommitted store is dropped.
  always_ff @(posedge clk) begin
    if (commit && wr_q && !err)
      mem[idx[AW-1:0]] <= wdata_q;
  end
endmodule
